// File: rtl/axi_dma_copy_master_if.sv
// axi_dma_copy_master_if: 128-bit AXI bus between the copy engine and memory.
// The master modport is the engine's view; slave is the memory side.
interface axi_dma_copy_master_if;
    logic         arvalid_m1;
    logic         arready_m1;
    logic [39:0]  araddr_m1;
    logic [7:0]   arlen_m1;
    logic [2:0]   arsize_m1;
    logic [1:0]   arburst_m1;
    logic [7:0]   arid_m1;
    logic         rvalid_m1;
    logic         rready_m1;
    logic [127:0] rdata_m1;
    logic [7:0]   rid_m1;
    logic         rlast_m1;
    logic [1:0]   rresp_m1;
    logic         awvalid_m1;
    logic         awready_m1;
    logic [39:0]  awaddr_m1;
    logic [7:0]   awlen_m1;
    logic [2:0]   awsize_m1;
    logic [1:0]   awburst_m1;
    logic [7:0]   awid_m1;
    logic         wvalid_m1;
    logic         wready_m1;
    logic [127:0] wdata_m1;
    logic [15:0]  wstrb_m1;
    logic         wlast_m1;
    logic [7:0]   wid_m1;
    logic         bvalid_m1;
    logic         bready_m1;
    logic [7:0]   bid_m1;
    logic [1:0]   bresp_m1;

    modport master (
        output arvalid_m1, araddr_m1, arlen_m1, arsize_m1, arburst_m1, arid_m1,
        input  arready_m1,
        input  rvalid_m1, rdata_m1, rid_m1, rlast_m1, rresp_m1,
        output rready_m1,
        output awvalid_m1, awaddr_m1, awlen_m1, awsize_m1, awburst_m1, awid_m1,
        input  awready_m1,
        output wvalid_m1, wdata_m1, wstrb_m1, wlast_m1, wid_m1,
        input  wready_m1,
        input  bvalid_m1, bid_m1, bresp_m1,
        output bready_m1
    );

    modport slave (
        input  arvalid_m1, araddr_m1, arlen_m1, arsize_m1, arburst_m1, arid_m1,
        output arready_m1,
        output rvalid_m1, rdata_m1, rid_m1, rlast_m1, rresp_m1,
        input  rready_m1,
        input  awvalid_m1, awaddr_m1, awlen_m1, awsize_m1, awburst_m1, awid_m1,
        output awready_m1,
        input  wvalid_m1, wdata_m1, wstrb_m1, wlast_m1, wid_m1,
        output wready_m1,
        output bvalid_m1, bid_m1, bresp_m1,
        input  bready_m1
    );
endinterface

// File: rtl/axi_dma_copy_master.sv
// axi_dma_copy_master: single-command AXI copy engine.
// Reads one burst into a local beat buffer, then writes it back out.
module axi_dma_copy_master #(
    parameter int unsigned BUF_DEPTH = 16,
    parameter logic [7:0]  AXI_ID    = 8'h5A
) (
    input  logic        pll_core_cpuclk,
    input  logic        pad_cpu_rst_b,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [39:0] cmd_src,
    input  logic [39:0] cmd_dst,
    input  logic [7:0]  cmd_len,
    output logic        done_valid,
    output logic        done_err,
    output logic        busy,
    axi_dma_copy_master_if.master m
);
    localparam int unsigned IW      = $clog2(BUF_DEPTH);
    localparam logic [7:0]  MAX_LEN = 8'(BUF_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE
    } state_e;

    state_e       state_q;
    logic [39:0]  src_q, dst_q;
    logic [7:0]   len_q, rcnt_q, wcnt_q;
    logic         arvalid_q, rready_q, awvalid_q, wvalid_q, wlast_q, bready_q;
    logic         done_q, derr_q, err_q;
    logic [127:0] wdata_q;
    logic [127:0] mem_q [BUF_DEPTH];

    logic          rd_fire, rd_bad, rd_end, b_bad, cmd_bad;
    logic [7:0]    wcnt_nx;
    logic [IW-1:0] ridx, widx_nx;

    assign rd_fire = rready_q & m.rvalid_m1;
    assign rd_bad  = (m.rresp_m1 != 2'b00) | (m.rid_m1 != AXI_ID)
                   | (m.rlast_m1 != (rcnt_q == len_q));
    // An early rlast ends the burst; its mismatch is already in rd_bad.
    assign rd_end  = (rcnt_q == len_q) | m.rlast_m1;
    assign b_bad   = (m.bresp_m1 != 2'b00) | (m.bid_m1 != AXI_ID);
    assign cmd_bad = (cmd_len > MAX_LEN)
                   | (({1'b0, cmd_src[11:4]} + {1'b0, cmd_len}) > 9'd255)
                   | (({1'b0, cmd_dst[11:4]} + {1'b0, cmd_len}) > 9'd255);
    assign wcnt_nx = wcnt_q + 8'd1;
    assign ridx    = rcnt_q[IW-1:0];
    assign widx_nx = wcnt_nx[IW-1:0];

    always_ff @(posedge pll_core_cpuclk) begin
        if (rd_fire) mem_q[ridx] <= m.rdata_m1;
    end

    always_ff @(posedge pll_core_cpuclk) begin
        if (!pad_cpu_rst_b) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            rcnt_q    <= '0;
            wcnt_q    <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
            done_q    <= 1'b0;
            derr_q    <= 1'b0;
            err_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (cmd_valid) begin
                    src_q  <= cmd_src;
                    dst_q  <= cmd_dst;
                    len_q  <= cmd_len;
                    rcnt_q <= '0;
                    wcnt_q <= '0;
                    if (cmd_bad) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        derr_q  <= 1'b1;
                    end else begin
                        state_q   <= RD_ADDR;
                        arvalid_q <= 1'b1;
                    end
                end
                RD_ADDR: if (m.arready_m1) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state_q   <= RD_DATA;
                end
                RD_DATA: if (m.rvalid_m1) begin
                    rcnt_q <= rcnt_q + 8'd1;
                    if (rd_bad) err_q <= 1'b1;
                    if (rd_end) begin
                        rready_q <= 1'b0;
                        if (err_q | rd_bad) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            derr_q  <= 1'b1;
                        end else begin
                            state_q   <= WR_ADDR;
                            awvalid_q <= 1'b1;
                        end
                    end
                end
                WR_ADDR: if (m.awready_m1) begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b1;
                    wlast_q   <= (len_q == 8'd0);
                    wdata_q   <= mem_q[{IW{1'b0}}];
                    state_q   <= WR_DATA;
                end
                WR_DATA: if (m.wready_m1) begin
                    wcnt_q <= wcnt_nx;
                    if (wlast_q) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end else begin
                        wdata_q <= mem_q[widx_nx];
                        wlast_q <= (wcnt_nx == len_q);
                    end
                end
                WR_RESP: if (m.bvalid_m1) begin
                    bready_q <= 1'b0;
                    done_q   <= 1'b1;
                    derr_q   <= err_q | b_bad;
                    state_q  <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    derr_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done_valid = done_q;
    assign done_err   = derr_q;

    assign m.arvalid_m1 = arvalid_q;
    assign m.araddr_m1  = src_q & ~40'hF;
    assign m.arlen_m1   = len_q;
    assign m.arsize_m1  = 3'b100;
    assign m.arburst_m1 = 2'b01;
    assign m.arid_m1    = AXI_ID;
    assign m.rready_m1  = rready_q;
    assign m.awvalid_m1 = awvalid_q;
    assign m.awaddr_m1  = dst_q & ~40'hF;
    assign m.awlen_m1   = len_q;
    assign m.awsize_m1  = 3'b100;
    assign m.awburst_m1 = 2'b01;
    assign m.awid_m1    = AXI_ID;
    assign m.wvalid_m1  = wvalid_q;
    assign m.wdata_m1   = wdata_q;
    assign m.wstrb_m1   = 16'hffff;
    assign m.wlast_m1   = wlast_q;
    assign m.wid_m1     = AXI_ID;
    assign m.bready_m1  = bready_q;
endmodule

// File: tb/tb_axi_dma_copy_master.sv
// tb_axi_dma_copy_master: directed copy commands against a small AXI memory model.
// The model checks handshake stability and records what was written.
module tb_axi_dma_copy_master;
    localparam logic [7:0]   ID   = 8'h5A;
    localparam logic [127:0] FILL = {4{32'hDEAD_BEEF}};

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [39:0] cmd_src = '0;
    logic [39:0] cmd_dst = '0;
    logic [7:0]  cmd_len = '0;
    logic        done_valid, done_err, busy;

    axi_dma_copy_master_if bus();

    axi_dma_copy_master #(.BUF_DEPTH(16), .AXI_ID(ID)) dut (
        .pll_core_cpuclk(clk),
        .pad_cpu_rst_b  (rst_b),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_src        (cmd_src),
        .cmd_dst        (cmd_dst),
        .cmd_len        (cmd_len),
        .done_valid     (done_valid),
        .done_err       (done_err),
        .busy           (busy),
        .m              (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [127:0] smem [logic [35:0]];

    function automatic logic [127:0] pat(input logic [35:0] a);
        logic [31:0] w;
        w = a[31:0];
        return {w ^ 32'hA5A5_0000, w + 32'h10, ~w, w * 32'd3};
    endfunction

    task automatic prefill(input logic [39:0] s, input logic [39:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            smem[s[39:4] + 36'(i)] = pat(s[39:4] + 36'(i));
            smem[d[39:4] + 36'(i)] = FILL;
        end
    endtask

    bit          stall = 0;
    int          err_beat = -1;
    logic [1:0]  bresp_inj = 2'b00;
    int          ar_cnt = 0, aw_cnt = 0;
    logic [39:0] last_araddr, last_awaddr;
    logic [7:0]  last_arlen;
    bit          r_act, r_take, ar_hold, aw_hold, w_act, w_hold, b_pend, b_take;
    logic [35:0] r_base, w_base;
    int          r_idx, r_len, w_idx, w_len;
    logic [39:0] ar_sv_addr, aw_sv_addr;
    logic [7:0]  ar_sv_len, aw_sv_len;
    logic [127:0] w_sv;
    int          overlap = 0, long_pulse = 0, done_cnt = 0;
    bit          done_prev = 0;

    function automatic bit go();
        return stall ? bit'($urandom_range(0, 1)) : 1'b1;
    endfunction

    task automatic slave_clr();
        bus.arready_m1 = 0; bus.rvalid_m1 = 0; bus.rdata_m1 = '0;
        bus.rid_m1 = '0; bus.rlast_m1 = 0; bus.rresp_m1 = '0;
        bus.awready_m1 = 0; bus.wready_m1 = 0;
        bus.bvalid_m1 = 0; bus.bid_m1 = '0; bus.bresp_m1 = '0;
        r_act = 0; r_take = 0; ar_hold = 0; aw_hold = 0;
        w_act = 0; w_hold = 0; b_pend = 0; b_take = 0;
    endtask

    // Memory-side responder: decides at negedge, transfers happen at next posedge.
    initial begin
        slave_clr();
        forever begin
            @(negedge clk);
            if (bus.arvalid_m1 && bus.awvalid_m1) overlap++;
            if (done_valid) begin
                done_cnt++;
                if (done_prev) long_pulse++;
            end
            done_prev = done_valid;
            if (!rst_b) begin
                slave_clr();
                continue;
            end
            if (r_take) begin bus.rvalid_m1 = 0; bus.rlast_m1 = 0; r_take = 0; end
            if (r_act && !bus.rvalid_m1 && go()) begin
                bus.rvalid_m1 = 1;
                bus.rdata_m1  = smem[r_base + 36'(r_idx)];
                bus.rlast_m1  = (r_idx == r_len);
                bus.rresp_m1  = (r_idx == err_beat) ? 2'b10 : 2'b00;
                bus.rid_m1    = ID;
            end
            if (bus.rvalid_m1 && bus.rready_m1) begin
                r_take = 1;
                r_idx++;
                if (r_idx > r_len) r_act = 0;
            end
            if (ar_hold) chk("ar_held", bus.arvalid_m1, 1'b1);
            bus.arready_m1 = go();
            if (bus.arvalid_m1) begin
                if (ar_hold) begin
                    chk("ar_addr_stable", bus.araddr_m1, ar_sv_addr);
                    chk("ar_len_stable", bus.arlen_m1, ar_sv_len);
                end
                if (bus.arready_m1) begin
                    ar_hold = 0;
                    ar_cnt++;
                    chk("ar_fixed", {bus.arsize_m1, bus.arburst_m1, bus.arid_m1},
                        {3'b100, 2'b01, ID});
                    last_araddr = bus.araddr_m1;
                    last_arlen  = bus.arlen_m1;
                    r_base = bus.araddr_m1[39:4];
                    r_len  = int'(bus.arlen_m1);
                    r_idx  = 0;
                    r_act  = 1;
                end else begin
                    ar_hold = 1;
                    ar_sv_addr = bus.araddr_m1;
                    ar_sv_len  = bus.arlen_m1;
                end
            end
            bus.wready_m1 = go();
            if (bus.wvalid_m1) begin
                chk("w_after_aw", w_act, 1'b1);
                if (w_hold) chk("w_data_stable", bus.wdata_m1, w_sv);
                if (bus.wready_m1 && w_act) begin
                    chk("wlast", bus.wlast_m1, (w_idx == w_len));
                    chk("wstrb_wid", {bus.wstrb_m1, bus.wid_m1}, {16'hffff, ID});
                    smem[w_base + 36'(w_idx)] = bus.wdata_m1;
                    w_idx++;
                    w_hold = 0;
                    if (w_idx > w_len) begin w_act = 0; b_pend = 1; end
                end else begin
                    w_hold = 1;
                    w_sv = bus.wdata_m1;
                end
            end
            if (aw_hold) chk("aw_held", bus.awvalid_m1, 1'b1);
            bus.awready_m1 = go();
            if (bus.awvalid_m1) begin
                if (aw_hold) begin
                    chk("aw_addr_stable", bus.awaddr_m1, aw_sv_addr);
                    chk("aw_len_stable", bus.awlen_m1, aw_sv_len);
                end
                if (bus.awready_m1) begin
                    aw_hold = 0;
                    aw_cnt++;
                    last_awaddr = bus.awaddr_m1;
                    w_base = bus.awaddr_m1[39:4];
                    w_len  = int'(bus.awlen_m1);
                    w_idx  = 0;
                    w_act  = 1;
                end else begin
                    aw_hold = 1;
                    aw_sv_addr = bus.awaddr_m1;
                    aw_sv_len  = bus.awlen_m1;
                end
            end
            if (b_take) begin bus.bvalid_m1 = 0; b_take = 0; end
            if (b_pend && !bus.bvalid_m1 && go()) begin
                bus.bvalid_m1 = 1;
                bus.bresp_m1  = bresp_inj;
                bus.bid_m1    = ID;
                b_pend = 0;
            end
            if (bus.bvalid_m1 && bus.bready_m1) b_take = 1;
        end
    end

    int n_cmd = 0;

    task automatic run_cmd(input logic [39:0] s, input logic [39:0] d,
                           input logic [7:0] l, output logic e, output int lat);
        int  t0;
        bit  got;
        @(negedge clk);
        cmd_src = s; cmd_dst = d; cmd_len = l; cmd_valid = 1;
        chk("cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        t0 = cyc;
        n_cmd++;
        got = 0; e = 1'bx; lat = -1;
        for (int i = 0; i < 400; i++) begin
            if (done_valid) begin
                got = 1; e = done_err; lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", got, 1'b1);
    endtask

    task automatic cmp_copy(input string tag, input logic [39:0] s,
                            input logic [39:0] d, input int n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), smem[d[39:4] + 36'(i)],
                pat(s[39:4] + 36'(i)));
    endtask

    initial begin
        logic e;
        int   lat, a0, w0, d0;

        repeat (3) @(negedge clk);
        chk("rst_valids", {bus.arvalid_m1, bus.rready_m1, bus.awvalid_m1,
                           bus.wvalid_m1, bus.wlast_m1, bus.bready_m1}, 6'b0);
        chk("rst_ctl", {busy, done_valid, done_err, cmd_ready}, 4'b0001);
        rst_b = 1;

        // single beat, zero-wait
        prefill(40'h1000, 40'h2000, 1);
        run_cmd(40'h1000, 40'h2000, 8'd0, e, lat);
        chk("t1_err", e, 1'b0);
        chk("t1_lat_min", (lat >= 5), 1'b1);
        chk("t1_ar", {last_araddr, last_arlen}, {40'h1000, 8'd0});
        chk("t1_aw", last_awaddr, 40'h2000);
        cmp_copy("t1", 40'h1000, 40'h2000, 1);

        // four beats with random stalls
        stall = 1;
        prefill(40'h100, 40'h400, 4);
        run_cmd(40'h100, 40'h400, 8'd3, e, lat);
        chk("t2_err", e, 1'b0);
        chk("t2_ar", {last_araddr, last_arlen}, {40'h100, 8'd3});
        chk("t2_aw", last_awaddr, 40'h400);
        cmp_copy("t2", 40'h100, 40'h400, 4);
        stall = 0;

        // rejected commands: too long, src and dst crossing 4 KB
        a0 = ar_cnt; w0 = aw_cnt;
        run_cmd(40'h1000, 40'h2000, 8'd16, e, lat);
        chk("t3_err", e, 1'b1);
        chk("t3_lat", (lat <= 1), 1'b1);
        run_cmd(40'hFF0, 40'h2000, 8'd1, e, lat);
        chk("t4_src_err", e, 1'b1);
        run_cmd(40'h3000, 40'h1FF0, 8'd1, e, lat);
        chk("t4_dst_err", e, 1'b1);
        chk("t34_no_ar", ar_cnt, a0);
        chk("t34_no_aw", aw_cnt, w0);

        // burst ending exactly at the 4 KB line is legal
        prefill(40'hFE0, 40'h3000, 2);
        run_cmd(40'hFE0, 40'h3000, 8'd1, e, lat);
        chk("t4_edge_err", e, 1'b0);
        cmp_copy("t4e", 40'hFE0, 40'h3000, 2);

        // full buffer, unaligned source address
        prefill(40'h5000, 40'h6000, 16);
        run_cmd(40'h5007, 40'h6000, 8'd15, e, lat);
        chk("t_full_err", e, 1'b0);
        chk("t_full_lat_min", (lat >= 35), 1'b1);
        chk("t_full_araddr", last_araddr, 40'h5000);
        cmp_copy("tf", 40'h5000, 40'h6000, 16);

        // read error on second beat, then a clean retry
        prefill(40'h7000, 40'h8000, 4);
        err_beat = 1;
        w0 = aw_cnt;
        run_cmd(40'h7000, 40'h8000, 8'd3, e, lat);
        chk("t5_err", e, 1'b1);
        chk("t5_no_aw", aw_cnt, w0);
        chk("t5_dst_kept", smem[36'h800], FILL);
        err_beat = -1;
        run_cmd(40'h7000, 40'h8000, 8'd3, e, lat);
        chk("t5_retry_err", e, 1'b0);
        cmp_copy("t5", 40'h7000, 40'h8000, 4);

        // write response error
        bresp_inj = 2'b10;
        prefill(40'h9000, 40'hA000, 1);
        run_cmd(40'h9000, 40'hA000, 8'd0, e, lat);
        chk("t_bresp_err", e, 1'b1);
        bresp_inj = 2'b00;

        // reset in the middle of the write burst
        prefill(40'hB000, 40'hC000, 4);
        @(negedge clk);
        cmd_src = 40'hB000; cmd_dst = 40'hC000; cmd_len = 8'd3; cmd_valid = 1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 0;
        begin
            bit hit;
            hit = 0;
            for (int i = 0; i < 100; i++) begin
                #1;
                if (bus.wvalid_m1 && w_idx == 2) begin hit = 1; break; end
                @(negedge clk);
            end
            chk("t6_reached_wr", hit, 1'b1);
        end
        d0 = done_cnt;
        rst_b = 0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_valids", {bus.arvalid_m1, bus.rready_m1, bus.awvalid_m1,
                          bus.wvalid_m1, bus.wlast_m1, bus.bready_m1}, 6'b0);
        chk("t6_ctl", {busy, done_valid, cmd_ready}, 3'b001);
        @(negedge clk);
        rst_b = 1;
        repeat (5) @(negedge clk);
        chk("t6_no_done", done_cnt, d0);

        run_cmd(40'h1000, 40'hD000, 8'd0, e, lat);
        chk("t6_recover_err", e, 1'b0);
        cmp_copy("t6r", 40'h1000, 40'hD000, 1);

        repeat (3) @(negedge clk);
        chk("ar_aw_overlap", overlap, 0);
        chk("done_one_cycle", long_pulse, 0);
        chk("done_count", done_cnt, n_cmd);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
